// File: rtl/fifo_read_packer.sv
// Read-domain consumer of the async FIFO: pops words whenever data is available,
// packs PACK_WORDS of them (first word in the LSBs) and offers the packet on valid/ready.
module fifo_read_packer #(
    parameter int MEMORY_WIDTH = 4,
    parameter int PACK_WORDS   = 4,
    parameter int READ_REG     = 1
) (
    input  logic                                 r_clk,
    input  logic                                 rrst_n,
    input  logic                                 r_empty,
    input  logic [MEMORY_WIDTH-1:0]              rdata,
    output logic                                 r_en,
    input  logic                                 flush,
    output logic [MEMORY_WIDTH*PACK_WORDS-1:0]   out_data,
    output logic [$clog2(PACK_WORDS+1)-1:0]      out_count,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int CNT_W = $clog2(PACK_WORDS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_WORDS);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                               state_r;
    logic [CNT_W-1:0]                     issued_r;
    logic [CNT_W-1:0]                     rcvd_r;
    logic                                 flush_pend_r;
    logic                                 rd_pend_r;
    logic [MEMORY_WIDTH*PACK_WORDS-1:0]   acc_r;
    logic [CNT_W-1:0]                     count_r;
    logic                                 valid_r;

    logic                                 r_en_s;
    logic                                 cap_s;
    logic                                 inflight_s;
    logic [CNT_W-1:0]                     rcvd_inc_s;

    // Pop request, capture strobe and in-flight indication for the selected read latency
    always_comb begin
        r_en_s     = 1'b0;
        cap_s      = 1'b0;
        inflight_s = 1'b0;
        rcvd_inc_s = rcvd_r + CNT_W'(1);
        if ((state_r == FILL) && !r_empty && (issued_r < FULL_CNT) && !flush_pend_r) begin
            r_en_s = 1'b1;
        end else begin
            r_en_s = 1'b0;
        end
        if (READ_REG != 0) begin
            cap_s      = rd_pend_r;
            inflight_s = rd_pend_r;
        end else begin
            cap_s      = r_en_s;
            inflight_s = 1'b0;
        end
    end

    // Packet accumulation and FILL/HOLD sequencing
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r      <= FILL;
            issued_r     <= '0;
            rcvd_r       <= '0;
            flush_pend_r <= 1'b0;
            rd_pend_r    <= 1'b0;
            acc_r        <= '0;
            count_r      <= '0;
            valid_r      <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (r_en_s) begin
                        issued_r <= issued_r + CNT_W'(1);
                    end
                    rd_pend_r <= (READ_REG != 0) ? r_en_s : 1'b0;
                    if (cap_s) begin
                        rcvd_r <= rcvd_inc_s;
                        for (int k = 0; k < PACK_WORDS; k++) begin
                            if (rcvd_r == CNT_W'(k)) begin
                                acc_r[k*MEMORY_WIDTH +: MEMORY_WIDTH] <= rdata;
                            end
                        end
                    end
                    // A landing last word wins over any flush arriving on the same edge
                    if (cap_s && (rcvd_inc_s == FULL_CNT)) begin
                        state_r <= HOLD;
                        valid_r <= 1'b1;
                        count_r <= FULL_CNT;
                    end else if (flush_pend_r && !inflight_s && (rcvd_r != '0)) begin
                        state_r <= HOLD;
                        valid_r <= 1'b1;
                        count_r <= rcvd_r;
                    end else if (flush && ((rcvd_r != '0) || inflight_s)) begin
                        flush_pend_r <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r      <= FILL;
                        valid_r      <= 1'b0;
                        acc_r        <= '0;
                        count_r      <= '0;
                        issued_r     <= '0;
                        rcvd_r       <= '0;
                        flush_pend_r <= 1'b0;
                        rd_pend_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= FILL;
                end
            endcase
        end
    end

    assign r_en      = r_en_s;
    assign out_data  = acc_r;
    assign out_count = count_r;
    assign out_valid = valid_r;

endmodule
